// File: rtl/sync_pkg.sv
// Shared constants and elaboration helpers for the filtered level synchronizer.
package sync_pkg;

  localparam int SYNC_MIN_WID    = 1;
  localparam int SYNC_MAX_WID    = 64;
  localparam int SYNC_MIN_STAGES = 2;
  localparam int SYNC_MAX_STAGES = 4;
  localparam int SYNC_MAX_FILT   = 255;

  // Ceiling log2, used to size the per-bit stability counter.
  function automatic int sync_clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res++;
      v = v >>> 1;
    end
    return res;
  endfunction

  function automatic bit sync_wid_ok(input int wid);
    return (wid >= SYNC_MIN_WID) && (wid <= SYNC_MAX_WID);
  endfunction

  function automatic bit sync_stages_ok(input int stages);
    return (stages >= SYNC_MIN_STAGES) && (stages <= SYNC_MAX_STAGES);
  endfunction

  function automatic bit sync_filt_ok(input int filt);
    return (filt >= 0) && (filt <= SYNC_MAX_FILT);
  endfunction

endpackage

// File: rtl/synchronizer_filtered_bit.sv
// One bit of the synchronizer: flop chain, optional stability filter and
// edge detection against the previous output level.
module synchronizer_filtered_bit
  import sync_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter int   FILT    = 0,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              s;
  logic              dout_prev_q;

  // Plain shift chain; no logic between stages so each flop has a full cycle to resolve.
  // NOTE: non-blocking so every stage captures its predecessor's value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {STAGES{RST_VAL}};
    else     sync_q <= {sync_q[STAGES-2:0], din_i};
  end

  assign s = sync_q[STAGES-1];

  if (FILT == 0) begin : g_nofilt
    assign dout_o = s;
  end else begin : g_filt
    localparam int CNT_W = (sync_clog2(FILT + 1) < 1) ? 1 : sync_clog2(FILT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;

    // Accept a new level only after it has differed from dout for FILT cycles in a row.
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
      cnt_d  = cnt_q;
      dout_d = dout_q;
      if (s == dout_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        dout_d = s;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Filter state; reset drops any partial count.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        dout_q <= RST_VAL;
      end else begin
        cnt_q  <= cnt_d;
        dout_q <= dout_d;
      end
    end

    assign dout_o = dout_q;
  end

  // Previous output level; loading RST_VAL here keeps reset itself from making a pulse.
  always_ff @(posedge clk) begin
    if (rst) dout_prev_q <= RST_VAL;
    else     dout_prev_q <= dout_o;
  end

  assign rise_o = dout_o & ~dout_prev_q;
  assign fall_o = ~dout_o & dout_prev_q;

endmodule

// File: rtl/synchronizer_filtered.sv
// WID independent level synchronizers with optional glitch filter, per-bit
// rise/fall pulses and a bus-wide change flag. No multi-bit coherency.
module synchronizer_filtered
  import sync_pkg::*;
#(
  parameter int             WID     = 1,
  parameter int             STAGES  = 2,
  parameter int             FILT    = 0,
  parameter logic [WID-1:0] RST_VAL = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WID-1:0] din,
  output logic [WID-1:0] dout,
  output logic [WID-1:0] rise,
  output logic [WID-1:0] fall,
  output logic           chg
);

  if (!sync_wid_ok(WID)) begin : g_bad_wid
    $error("synchronizer_filtered: WID out of range");
  end
  if (!sync_stages_ok(STAGES)) begin : g_bad_stages
    $error("synchronizer_filtered: STAGES out of range");
  end
  if (!sync_filt_ok(FILT)) begin : g_bad_filt
    $error("synchronizer_filtered: FILT out of range");
  end

  for (genvar i = 0; i < WID; i++) begin : g_bit
    synchronizer_filtered_bit #(
      .STAGES  (STAGES),
      .FILT    (FILT),
      .RST_VAL (RST_VAL[i])
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .din_i  (din[i]),
      .dout_o (dout[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

  assign chg = |(rise | fall);

endmodule
